// File: rtl/pll_lock_sequencer_pkg.sv
// rtl/pll_lock_sequencer_pkg.sv - shared state enum and default timing for the PLL lock sequencer
package pll_lock_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_PLL_RST   = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABLE    = 3'd2,
        ST_HOLD      = 3'd3,
        ST_RUN       = 3'd4,
        ST_FAIL      = 3'd5
    } state_e;

    localparam int unsigned DEF_PLL_RST_CYCLES = 16;
    localparam int unsigned DEF_STABLE_CYCLES  = 1024;
    localparam int unsigned DEF_HOLD_CYCLES    = 64;
    localparam int unsigned DEF_LOCK_TIMEOUT   = 65536;
    localparam int unsigned DEF_MAX_RETRIES    = 4;
    localparam int unsigned DEF_CNT_W          = 8;

    function automatic int unsigned max_of4(input int unsigned a, input int unsigned b,
                                            input int unsigned c, input int unsigned d);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/pll_lock_sequencer_if.sv
// rtl/pll_lock_sequencer_if.sv - PLL lock / core reset control and status bundle
interface pll_lock_sequencer_if #(
    parameter int unsigned CNT_W = 8
);
    logic             pll_locked;
    logic             sw_reset_req;
    logic             pll_rst;
    logic             core_rst_n;
    logic             pll_ok;
    logic             fail;
    logic [CNT_W-1:0] loss_count;

    modport master (
        input  pll_locked, sw_reset_req,
        output pll_rst, core_rst_n, pll_ok, fail, loss_count
    );

    modport slave (
        output pll_locked, sw_reset_req,
        input  pll_rst, core_rst_n, pll_ok, fail, loss_count
    );
endinterface

// File: rtl/pll_lock_sequencer_sync_2ff.sv
// rtl/pll_lock_sequencer_sync_2ff.sv - generic two-flop single-bit synchronizer, resets to 0
module sync_2ff (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);
    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;
endmodule

// File: rtl/pll_lock_sequencer.sv
// rtl/pll_lock_sequencer.sv - PLL reset/lock qualification FSM with retry limit and core reset release
module pll_lock_sequencer
    import pll_lock_sequencer_pkg::*;
#(
    parameter int unsigned PLL_RST_CYCLES = DEF_PLL_RST_CYCLES,
    parameter int unsigned STABLE_CYCLES  = DEF_STABLE_CYCLES,
    parameter int unsigned HOLD_CYCLES    = DEF_HOLD_CYCLES,
    parameter int unsigned LOCK_TIMEOUT   = DEF_LOCK_TIMEOUT,
    parameter int unsigned MAX_RETRIES    = DEF_MAX_RETRIES,
    parameter int unsigned CNT_W          = DEF_CNT_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    pll_lock_sequencer_if.master  seq_if
);
    localparam int unsigned TMAX = max_of4(PLL_RST_CYCLES, STABLE_CYCLES, HOLD_CYCLES, LOCK_TIMEOUT);
    localparam int unsigned CW   = $clog2(TMAX) + 1;
    localparam int unsigned RW   = $clog2(MAX_RETRIES) + 1;

    localparam logic [CW-1:0] RST_END    = CW'(PLL_RST_CYCLES - 1);
    localparam logic [CW-1:0] STABLE_END = CW'(STABLE_CYCLES - 1);
    localparam logic [CW-1:0] HOLD_END   = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] WAIT_END   = CW'(LOCK_TIMEOUT - 1);
    localparam logic [RW-1:0] RETRY_LIM  = RW'(MAX_RETRIES);

    logic             lk;
    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [RW-1:0]    retry_q, retry_d;
    logic             from_run_q, from_run_d;
    logic [CNT_W-1:0] loss_q, loss_d;
    logic             loss_inc;
    logic             pll_rst_q, core_rst_n_q, pll_ok_q, fail_q;

    sync_2ff u_lock_sync (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .d_i    (seq_if.pll_locked),
        .q_o    (lk)
    );

    // cnt counts cycles spent in the current timed state; every transition clears it
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q + CW'(1);
        retry_d    = retry_q;
        from_run_d = from_run_q;
        loss_inc   = 1'b0;
        unique case (state_q)
            ST_PLL_RST: begin
                if (cnt_q == RST_END) begin
                    state_d = ST_WAIT_LOCK;
                    cnt_d   = '0;
                end
            end
            ST_WAIT_LOCK: begin
                if (lk) begin
                    state_d = ST_STABLE;
                    cnt_d   = '0;
                end else if (cnt_q == WAIT_END) begin
                    retry_d = retry_q + RW'(1);
                    cnt_d   = '0;
                    state_d = (retry_d == RETRY_LIM) ? ST_FAIL : ST_PLL_RST;
                end
            end
            ST_STABLE: begin
                if (!lk) begin
                    state_d = ST_WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q == STABLE_END) begin
                    state_d    = ST_HOLD;
                    cnt_d      = '0;
                    from_run_d = 1'b0;
                end
            end
            ST_HOLD: begin
                if (!lk) begin
                    state_d  = ST_PLL_RST;
                    cnt_d    = '0;
                    loss_inc = from_run_q;
                end else if (cnt_q == HOLD_END) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                    retry_d = '0;
                end
            end
            ST_RUN: begin
                cnt_d = '0;
                if (!lk) begin
                    state_d  = ST_PLL_RST;
                    loss_inc = 1'b1;
                end else if (seq_if.sw_reset_req) begin
                    state_d    = ST_HOLD;
                    from_run_d = 1'b1;
                end
            end
            ST_FAIL: begin
                cnt_d = '0;
            end
            default: begin
                state_d = ST_PLL_RST;
                cnt_d   = '0;
            end
        endcase
        loss_d = (loss_inc && (loss_q != {CNT_W{1'b1}})) ? loss_q + CNT_W'(1) : loss_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_PLL_RST;
            cnt_q        <= '0;
            retry_q      <= '0;
            from_run_q   <= 1'b0;
            loss_q       <= '0;
            pll_rst_q    <= 1'b1;
            core_rst_n_q <= 1'b0;
            pll_ok_q     <= 1'b0;
            fail_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            retry_q      <= retry_d;
            from_run_q   <= from_run_d;
            loss_q       <= loss_d;
            pll_rst_q    <= (state_d == ST_PLL_RST) || (state_d == ST_FAIL);
            core_rst_n_q <= (state_d == ST_RUN);
            pll_ok_q     <= (state_d == ST_RUN);
            fail_q       <= (state_d == ST_FAIL);
        end
    end

    assign seq_if.pll_rst    = pll_rst_q;
    assign seq_if.core_rst_n = core_rst_n_q;
    assign seq_if.pll_ok     = pll_ok_q;
    assign seq_if.fail       = fail_q;
    assign seq_if.loss_count = loss_q;
endmodule
